cart_map_arbiter: RTL and testbench

- Registered, parametrised arbiter for the cartridge-side bus, replacing the purely combinational mapper select.
- Selects one of NUM_MAPS coprocessor mapper channels, or the base (default) mapper channel, from a map-active vector.
- Drives CPU read data, IRQ, ROM and BSRAM buses to the core top level.
- Adds a quiesce window on every mapper switch, multi-hot detection, and one-cycle registered outputs.

---
 rtl/cart_arb_pkg.sv | 33 +++
 rtl/cart_arb_chsel.sv | 48 ++++
 rtl/cart_map_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_cart_map_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cart_arb_pkg.sv
// Shared types, idle constants and request decoding for the cartridge bus arbiter.
package cart_arb_pkg;

   typedef enum logic {ST_SETTLE, ST_ACTIVE} state_e;

   localparam logic [7:0] IDLE_DI     = 8'hFF;
   localparam logic       IDLE_STROBE = 1'b1;

   typedef struct packed {
      logic       valid;
      logic       multi;
      logic [3:0] idx;
   } req_t;

   // Only the low n bits are considered; idx is the channel number (bit k -> channel k+1).
   function automatic req_t onehot_to_idx(input logic [7:0] vec, input int unsigned n);
      req_t r;
      r = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < n && vec[i[2:0]]) begin
            if (r.valid || r.multi) begin
               r.valid = 1'b0;
               r.multi = 1'b1;
            end else begin
               r.valid = 1'b1;
               r.idx   = 4'(i + 1);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cart_arb_chsel.sv
// Combinational extractor: picks channel idx's bus bundle out of the flattened inputs.
module cart_arb_chsel
   import cart_arb_pkg::*;
#(
   parameter int NUM_MAPS = 4,
   parameter int ROM_AW   = 24,
   parameter int BSRAM_AW = 20
) (
   input  logic [3:0]                       idx,
   input  logic [8*(NUM_MAPS+1)-1:0]        ch_do,
   input  logic [NUM_MAPS:0]                ch_irq_n,
   input  logic [ROM_AW*(NUM_MAPS+1)-1:0]   ch_rom_addr,
   input  logic [3*(NUM_MAPS+1)-1:0]        ch_rom_ctl,
   input  logic [BSRAM_AW*(NUM_MAPS+1)-1:0] ch_bsram_addr,
   input  logic [8*(NUM_MAPS+1)-1:0]        ch_bsram_d,
   input  logic [3*(NUM_MAPS+1)-1:0]        ch_bsram_ctl,
   output logic [7:0]                       sel_do,
   output logic                             sel_irq_n,
   output logic [ROM_AW-1:0]                sel_rom_addr,
   output logic [2:0]                       sel_rom_ctl,
   output logic [BSRAM_AW-1:0]              sel_bsram_addr,
   output logic [7:0]                       sel_bsram_d,
   output logic [2:0]                       sel_bsram_ctl
);

   // An out-of-range index yields an idle bundle rather than reading past the vectors.
   always_comb begin
      sel_do         = IDLE_DI;
      sel_irq_n      = IDLE_STROBE;
      sel_rom_addr   = '0;
      sel_rom_ctl    = {1'b0, IDLE_STROBE, IDLE_STROBE};
      sel_bsram_addr = '0;
      sel_bsram_d    = '0;
      sel_bsram_ctl  = {3{IDLE_STROBE}};
      for (int k = 0; k <= NUM_MAPS; k++) begin
         if (idx == 4'(k)) begin
            sel_do         = ch_do[8*k +: 8];
            sel_irq_n      = ch_irq_n[k];
            sel_rom_addr   = ch_rom_addr[ROM_AW*k +: ROM_AW];
            sel_rom_ctl    = ch_rom_ctl[3*k +: 3];
            sel_bsram_addr = ch_bsram_addr[BSRAM_AW*k +: BSRAM_AW];
            sel_bsram_d    = ch_bsram_d[8*k +: 8];
            sel_bsram_ctl  = ch_bsram_ctl[3*k +: 3];
         end
      end
   end

endmodule

// File: rtl/cart_map_arbiter.sv
// Registered cartridge mapper arbiter with quiesce window on every channel switch.
// Define CART_ARB_STATS_EN to add switch_count/err_count statistics outputs.
module cart_map_arbiter
   import cart_arb_pkg::*;
#(
   parameter int NUM_MAPS      = 4,
   parameter int ROM_AW        = 24,
   parameter int BSRAM_AW      = 20,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                             mclk,
   input  logic                             rst,
   input  logic [NUM_MAPS-1:0]              map_active,
   input  logic [8*(NUM_MAPS+1)-1:0]        ch_do,
   input  logic [NUM_MAPS:0]                ch_irq_n,
   input  logic [ROM_AW*(NUM_MAPS+1)-1:0]   ch_rom_addr,
   input  logic [3*(NUM_MAPS+1)-1:0]        ch_rom_ctl,
   input  logic [BSRAM_AW*(NUM_MAPS+1)-1:0] ch_bsram_addr,
   input  logic [8*(NUM_MAPS+1)-1:0]        ch_bsram_d,
   input  logic [3*(NUM_MAPS+1)-1:0]        ch_bsram_ctl,
   output logic [7:0]                       di,
   output logic                             irq_n,
   output logic [ROM_AW-1:0]                rom_addr,
   output logic                             rom_ce_n,
   output logic                             rom_oe_n,
   output logic                             rom_word,
   output logic [BSRAM_AW-1:0]              bsram_addr,
   output logic [7:0]                       bsram_d,
   output logic                             bsram_ce_n,
   output logic                             bsram_oe_n,
   output logic                             bsram_we_n,
   output logic [3:0]                       sel,
   output logic                             settling,
`ifdef CART_ARB_STATS_EN
   output logic [7:0]                       switch_count,
   output logic [7:0]                       err_count,
`endif
   output logic                             multi_err
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_e     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic [3:0] target_q, target_d;
   logic [3:0] sel_q, sel_d;
   req_t       req;
   logic [3:0] req_ch;

   logic [7:0]          c_do;
   logic                c_irq_n;
   logic [ROM_AW-1:0]   c_rom_addr;
   logic [2:0]          c_rom_ctl;
   logic [BSRAM_AW-1:0] c_bsram_addr;
   logic [7:0]          c_bsram_d;
   logic [2:0]          c_bsram_ctl;

   always_comb begin
      req    = onehot_to_idx(8'(map_active), NUM_MAPS);
      req_ch = req.valid ? req.idx : 4'd0;
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      sel_d    = sel_q;
      case (state_q)
         ST_ACTIVE: begin
            if (req_ch != sel_q) begin
               state_d  = ST_SETTLE;
               target_d = req_ch;
               count_d  = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (req_ch != target_q) begin
               target_d = req_ch;
               count_d  = SETTLE_LOAD;
            end else if (count_q == 4'd1) begin
               sel_d   = target_q;
               state_d = ST_ACTIVE;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         default: state_d = ST_SETTLE;
      endcase
   end

   // Looks up the next grant so new-channel data lands on the same edge as the grant.
   cart_arb_chsel #(
      .NUM_MAPS (NUM_MAPS),
      .ROM_AW   (ROM_AW),
      .BSRAM_AW (BSRAM_AW)
   ) u_chsel (
      .idx            (sel_d),
      .ch_do          (ch_do),
      .ch_irq_n       (ch_irq_n),
      .ch_rom_addr    (ch_rom_addr),
      .ch_rom_ctl     (ch_rom_ctl),
      .ch_bsram_addr  (ch_bsram_addr),
      .ch_bsram_d     (ch_bsram_d),
      .ch_bsram_ctl   (ch_bsram_ctl),
      .sel_do         (c_do),
      .sel_irq_n      (c_irq_n),
      .sel_rom_addr   (c_rom_addr),
      .sel_rom_ctl    (c_rom_ctl),
      .sel_bsram_addr (c_bsram_addr),
      .sel_bsram_d    (c_bsram_d),
      .sel_bsram_ctl  (c_bsram_ctl)
   );

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SETTLE;
         count_q  <= SETTLE_LOAD;
         target_q <= 4'd0;
         sel_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         sel_q    <= sel_d;
      end
   end

   // Addresses hold through the quiesce window; strobes, data and IRQ are forced idle.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         di         <= IDLE_DI;
         irq_n      <= IDLE_STROBE;
         rom_addr   <= '0;
         rom_ce_n   <= IDLE_STROBE;
         rom_oe_n   <= IDLE_STROBE;
         rom_word   <= 1'b0;
         bsram_addr <= '0;
         bsram_d    <= '0;
         bsram_ce_n <= IDLE_STROBE;
         bsram_oe_n <= IDLE_STROBE;
         bsram_we_n <= IDLE_STROBE;
         settling   <= 1'b1;
         multi_err  <= 1'b0;
      end else begin
         settling  <= (state_d == ST_SETTLE);
         multi_err <= multi_err | req.multi;
         if (state_d == ST_ACTIVE) begin
            di                               <= c_do;
            irq_n                            <= c_irq_n;
            rom_addr                         <= c_rom_addr;
            {rom_word, rom_oe_n, rom_ce_n}   <= c_rom_ctl;
            bsram_addr                       <= c_bsram_addr;
            bsram_d                          <= c_bsram_d;
            {bsram_we_n, bsram_oe_n, bsram_ce_n} <= c_bsram_ctl;
         end else begin
            di         <= IDLE_DI;
            irq_n      <= IDLE_STROBE;
            rom_ce_n   <= IDLE_STROBE;
            rom_oe_n   <= IDLE_STROBE;
            rom_word   <= 1'b0;
            bsram_d    <= '0;
            bsram_ce_n <= IDLE_STROBE;
            bsram_oe_n <= IDLE_STROBE;
            bsram_we_n <= IDLE_STROBE;
         end
      end
   end

   assign sel = sel_q;

`ifdef CART_ARB_STATS_EN
   logic       multi_prev_q;
   logic [7:0] switch_cnt_q, err_cnt_q;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         multi_prev_q <= 1'b0;
         switch_cnt_q <= 8'd0;
         err_cnt_q    <= 8'd0;
      end else begin
         multi_prev_q <= req.multi;
         if (state_q == ST_SETTLE && state_d == ST_ACTIVE && sel_d != sel_q &&
             switch_cnt_q != 8'hFF) begin
            switch_cnt_q <= switch_cnt_q + 8'd1;
         end
         if (req.multi && !multi_prev_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign switch_count = switch_cnt_q;
   assign err_count    = err_cnt_q;
`endif

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Directed scoreboard bench for cart_map_arbiter (NUM_MAPS=4, SETTLE_CYCLES=4).
module tb_cart_map_arbiter;

   localparam int NM  = 4;
   localparam int RAW = 24;
   localparam int BAW = 20;

   logic                    mclk = 1'b0;
   logic                    rst  = 1'b1;
   logic [NM-1:0]           map_active = '0;
   logic [8*(NM+1)-1:0]     ch_do;
   logic [NM:0]             ch_irq_n;
   logic [RAW*(NM+1)-1:0]   ch_rom_addr;
   logic [3*(NM+1)-1:0]     ch_rom_ctl;
   logic [BAW*(NM+1)-1:0]   ch_bsram_addr;
   logic [8*(NM+1)-1:0]     ch_bsram_d;
   logic [3*(NM+1)-1:0]     ch_bsram_ctl;
   logic [7:0]              di;
   logic                    irq_n;
   logic [RAW-1:0]          rom_addr;
   logic                    rom_ce_n, rom_oe_n, rom_word;
   logic [BAW-1:0]          bsram_addr;
   logic [7:0]              bsram_d;
   logic                    bsram_ce_n, bsram_oe_n, bsram_we_n;
   logic [3:0]              sel;
   logic                    settling;
   logic                    multi_err;
`ifdef CART_ARB_STATS_EN
   logic [7:0]              switch_count, err_count;
`endif

   cart_map_arbiter #(
      .NUM_MAPS      (NM),
      .ROM_AW        (RAW),
      .BSRAM_AW      (BAW),
      .SETTLE_CYCLES (4)
   ) dut (
      .mclk          (mclk),
      .rst           (rst),
      .map_active    (map_active),
      .ch_do         (ch_do),
      .ch_irq_n      (ch_irq_n),
      .ch_rom_addr   (ch_rom_addr),
      .ch_rom_ctl    (ch_rom_ctl),
      .ch_bsram_addr (ch_bsram_addr),
      .ch_bsram_d    (ch_bsram_d),
      .ch_bsram_ctl  (ch_bsram_ctl),
      .di            (di),
      .irq_n         (irq_n),
      .rom_addr      (rom_addr),
      .rom_ce_n      (rom_ce_n),
      .rom_oe_n      (rom_oe_n),
      .rom_word      (rom_word),
      .bsram_addr    (bsram_addr),
      .bsram_d       (bsram_d),
      .bsram_ce_n    (bsram_ce_n),
      .bsram_oe_n    (bsram_oe_n),
      .bsram_we_n    (bsram_we_n),
      .sel           (sel),
      .settling      (settling),
`ifdef CART_ARB_STATS_EN
      .switch_count  (switch_count),
      .err_count     (err_count),
`endif
      .multi_err     (multi_err)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      string      tag;
      logic [3:0] sel;
      logic       settling;
      logic [7:0] di;
      logic       irq_n;
      logic [23:0] rom_addr;
      logic       rom_ce_n;
      logic       bsram_we_n;
      logic [7:0] bsram_d;
      logic       multi_err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   logic [7:0]  c_do [0:NM];
   logic        c_irq[0:NM];
   logic [23:0] c_ra [0:NM];
   logic [2:0]  c_rc [0:NM];
   logic [19:0] c_ba [0:NM];
   logic [7:0]  c_bd [0:NM];
   logic [2:0]  c_bc [0:NM];

   task automatic pack();
      for (int k = 0; k <= NM; k++) begin
         ch_do[8*k +: 8]          = c_do[k];
         ch_irq_n[k]              = c_irq[k];
         ch_rom_addr[RAW*k +: RAW] = c_ra[k];
         ch_rom_ctl[3*k +: 3]     = c_rc[k];
         ch_bsram_addr[BAW*k +: BAW] = c_ba[k];
         ch_bsram_d[8*k +: 8]     = c_bd[k];
         ch_bsram_ctl[3*k +: 3]   = c_bc[k];
      end
   endtask

   function automatic exp_t act(input string tag, input int k, input logic me);
      exp_t e;
      e.tag = tag; e.sel = 4'(k); e.settling = 1'b0; e.di = c_do[k]; e.irq_n = c_irq[k];
      e.rom_addr = c_ra[k]; e.rom_ce_n = c_rc[k][0]; e.bsram_we_n = c_bc[k][2];
      e.bsram_d = c_bd[k]; e.multi_err = me;
      return e;
   endfunction

   function automatic exp_t idl(input string tag, input int s, input logic [23:0] ra,
                                input logic me);
      exp_t e;
      e.tag = tag; e.sel = 4'(s); e.settling = 1'b1; e.di = 8'hFF; e.irq_n = 1'b1;
      e.rom_addr = ra; e.rom_ce_n = 1'b1; e.bsram_we_n = 1'b1; e.bsram_d = 8'h00;
      e.multi_err = me;
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_front();
      exp_t e;
      e = sb.pop_front();
      cmp({e.tag, ".sel"},        32'(sel),        32'(e.sel));
      cmp({e.tag, ".settling"},   32'(settling),   32'(e.settling));
      cmp({e.tag, ".di"},         32'(di),         32'(e.di));
      cmp({e.tag, ".irq_n"},      32'(irq_n),      32'(e.irq_n));
      cmp({e.tag, ".rom_addr"},   32'(rom_addr),   32'(e.rom_addr));
      cmp({e.tag, ".rom_ce_n"},   32'(rom_ce_n),   32'(e.rom_ce_n));
      cmp({e.tag, ".bsram_we_n"}, 32'(bsram_we_n), 32'(e.bsram_we_n));
      cmp({e.tag, ".bsram_d"},    32'(bsram_d),    32'(e.bsram_d));
      cmp({e.tag, ".multi_err"},  32'(multi_err),  32'(e.multi_err));
   endtask

   task automatic cyc(input exp_t e);
      sb.push_back(e);
      @(posedge mclk);
      #1;
      check_front();
   endtask

   task automatic chk_now(input exp_t e);
      sb.push_back(e);
      check_front();
   endtask

   initial begin
      for (int k = 0; k <= NM; k++) begin
         c_do[k]  = 8'hA0 + 8'(k);
         c_irq[k] = 1'b1;
         c_ra[k]  = (k == 0) ? 24'h00FFC0 : 24'h100000 * 24'(k) + 24'h000123;
         c_rc[k]  = (k == 0) ? 3'b000 : 3'b100;
         c_ba[k]  = 20'h00111 * 20'(k);
         c_bd[k]  = 8'h50 + 8'(k);
         c_bc[k]  = (k == 0) ? 3'b111 : 3'b010;
      end
      pack();

      repeat (2) @(posedge mclk);
      #1;
      chk_now(idl("reset", 0, 24'h0, 1'b0));
      rst = 1'b0;

      // Boot: three more quiesce cycles, then base channel.
      repeat (3) cyc(idl("boot_settle", 0, 24'h0, 1'b0));
      cyc(act("boot_active", 0, 1'b0));
      cyc(act("hold_ch0", 0, 1'b0));

      map_active = 4'b0100;
      repeat (4) cyc(idl("sw3_settle", 0, c_ra[0], 1'b0));
      cyc(act("sw3_active", 3, 1'b0));

      // Redirect mid-window: count reloads, channel 1 never granted.
      map_active = 4'b0001;
      repeat (3) cyc(idl("redir_a", 3, c_ra[3], 1'b0));
      map_active = 4'b1000;
      repeat (4) cyc(idl("redir_b", 3, c_ra[3], 1'b0));
      cyc(act("redir_active", 4, 1'b0));

      map_active = 4'b0110;
      repeat (4) cyc(idl("multi_settle", 4, c_ra[4], 1'b1));
      cyc(act("multi_base", 0, 1'b1));
      map_active = 4'b0010;
      repeat (4) cyc(idl("multi_recover", 0, c_ra[0], 1'b1));
      cyc(act("sticky_ch2", 2, 1'b1));

      c_irq[1] = 1'b0;
      pack();
      map_active = 4'b0001;
      repeat (4) cyc(idl("to_ch1", 2, c_ra[2], 1'b1));
      cyc(act("ch1_irq", 1, 1'b1));
      map_active = 4'b0000;
      repeat (2) cyc(idl("irq_drop", 1, c_ra[1], 1'b1));

      #3 rst = 1'b1;
      #1 chk_now(idl("async_rst", 0, 24'h0, 1'b0));
      @(posedge mclk);
      #1 rst = 1'b0;
      repeat (3) cyc(idl("reboot_settle", 0, 24'h0, 1'b0));
      cyc(act("reboot_active", 0, 1'b0));

`ifdef CART_ARB_STATS_EN
      for (int i = 0; i < 300; i++) begin
         map_active = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         repeat (6) @(posedge mclk);
      end
      #1;
      cmp("switch_sat", 32'(switch_count), 32'd255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
